// File: rtl/ucaspian_pkg.sv
// ucaspian_pkg: shared widths, synapse-stage state encoding and config byte indices
package ucaspian_pkg;
  localparam int SYN_AW = 12;
  localparam int NRN_AW = 8;
  localparam int WGT_W = 8;
  localparam int RAM_W = WGT_W + NRN_AW;
  typedef enum logic [1:0] {IDLE, RUN, CLEAR} syn_state_t;
  localparam logic [2:0] CFG_CLR = 3'd1;
  localparam logic [2:0] CFG_WGT = 3'd2;
  localparam logic [2:0] CFG_TGT = 3'd3;
endpackage

// File: rtl/ucaspian_synapse_if.sv
// ucaspian_synapse_if: axon range input and dendrite event output handshakes
interface ucaspian_synapse_if;
  import ucaspian_pkg::*;
  logic [SYN_AW-1:0] syn_start;
  logic [SYN_AW-1:0] syn_end;
  logic syn_vld;
  logic syn_rdy;
  logic [NRN_AW-1:0] dend_addr;
  logic [WGT_W-1:0] dend_charge;
  logic dend_vld;
  logic dend_rdy;
  modport master(output syn_start, syn_end, syn_vld, dend_rdy,
                 input syn_rdy, dend_addr, dend_charge, dend_vld);
  modport slave(input syn_start, syn_end, syn_vld, dend_rdy,
                output syn_rdy, dend_addr, dend_charge, dend_vld);
endinterface

// File: rtl/dp_ram_16x4096.sv
// dp_ram_16x4096: synapse RAM, one write port and one registered read port
module dp_ram_16x4096
  import ucaspian_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [SYN_AW-1:0] waddr,
  input  logic [RAM_W-1:0]  wdata,
  input  logic              re,
  input  logic [SYN_AW-1:0] raddr,
  output logic [RAM_W-1:0]  rdata
);
  logic [RAM_W-1:0] mem [2**SYN_AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ucaspian_synapse.sv
// ucaspian_synapse: walks an inclusive synapse range through RAM and emits nonzero-weight dendrite events
module ucaspian_synapse
  import ucaspian_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear_act,
  input  logic              clear_config,
  output logic              clear_done,
  input  logic [SYN_AW-1:0] config_addr,
  input  logic [7:0]        config_value,
  input  logic [2:0]        config_byte,
  input  logic              config_enable,
  input  logic              next_step,
  output logic              step_done,
  ucaspian_synapse_if.slave syn
);
  syn_state_t state;
  logic [SYN_AW-1:0] rd_addr, end_addr, clr_cnt, ram_wa;
  logic [RAM_W-1:0] rdata, ram_wd;
  logic [WGT_W-1:0] stage_w, h_chg;
  logic [NRN_AW-1:0] h_addr;
  logic [1:0] occ;
  logic clr_fin, rd_pend, h_vld, issue, accept, push, out_free, ram_we, unused_ok;
  // step_done is recomputed every cycle, so the timestep boundary needs no action here
  assign unused_ok = next_step;
  assign syn.syn_rdy = state == IDLE && enable && !clear_act && !clear_config && !reset;
  assign accept = syn.syn_vld && syn.syn_rdy;
  assign push = rd_pend && |rdata[RAM_W-1:NRN_AW];
  assign out_free = !syn.dend_vld || syn.dend_rdy;
  // items held after this edge must leave room for a read issued now
  assign occ = {1'b0, syn.dend_vld} + {1'b0, h_vld} + {1'b0, rd_pend} - {1'b0, syn.dend_vld && syn.dend_rdy};
  assign issue = state == RUN && occ <= 2'd1 && !clear_act && !clear_config;
  assign ram_we = !reset && (clear_config ? !clr_fin : config_enable && config_byte == CFG_TGT);
  assign ram_wa = clear_config ? clr_cnt : config_addr;
  assign ram_wd = clear_config ? '0 : {stage_w, config_value};
  dp_ram_16x4096 u_ram (
    .clk(clk), .we(ram_we), .waddr(ram_wa), .wdata(ram_wd),
    .re(issue), .raddr(rd_addr), .rdata(rdata)
  );
  always_ff @(posedge clk) begin
    if (reset) stage_w <= '0;
    else if (config_enable && !clear_config)
      stage_w <= config_byte == CFG_CLR ? '0 : config_byte == CFG_WGT ? config_value : stage_w;
  end
  always_ff @(posedge clk) begin
    if (reset || !clear_config) begin
      clr_cnt <= '0;
      clr_fin <= 1'b0;
    end else if (!clr_fin) begin
      clr_cnt <= clr_cnt + SYN_AW'(1);
      clr_fin <= &clr_cnt;
    end
    clear_done <= !reset && (clear_act || (clear_config && (clr_fin || &clr_cnt)));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rd_addr <= '0;
      end_addr <= '0;
      rd_pend <= 1'b0;
      h_vld <= 1'b0;
      h_addr <= '0;
      h_chg <= '0;
      syn.dend_vld <= 1'b0;
      syn.dend_addr <= '0;
      syn.dend_charge <= '0;
      step_done <= 1'b0;
    end else if (clear_act || clear_config) begin
      state <= clear_config ? CLEAR : IDLE;
      rd_pend <= 1'b0;
      h_vld <= 1'b0;
      syn.dend_vld <= 1'b0;
      step_done <= 1'b0;
    end else begin
      step_done <= state == IDLE && !syn.syn_vld && !syn.dend_vld && !h_vld && !rd_pend;
      rd_pend <= issue;
      if (state == CLEAR) state <= IDLE;
      else if (accept) begin
        state <= RUN;
        rd_addr <= syn.syn_start;
        end_addr <= syn.syn_end;
      end else if (issue) begin
        rd_addr <= rd_addr + SYN_AW'(1);
        if (rd_addr == end_addr) state <= IDLE;
      end
      // output register refills from hold first to preserve address order
      if (out_free) begin
        syn.dend_vld <= h_vld || push;
        if (h_vld || push)
          {syn.dend_addr, syn.dend_charge} <= h_vld ? {h_addr, h_chg} : {rdata[NRN_AW-1:0], rdata[RAM_W-1:NRN_AW]};
      end
      h_vld <= out_free ? h_vld && push : h_vld || push;
      if (push) {h_addr, h_chg} <= {rdata[NRN_AW-1:0], rdata[RAM_W-1:NRN_AW]};
    end
  end
endmodule

// File: tb/tb_ucaspian_synapse.sv
// tb_ucaspian_synapse: directed checks of range walking, backpressure, wrap, clears and step_done
module tb_ucaspian_synapse;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b1, clear_act = 1'b0, clear_config = 1'b0;
  logic clear_done, step_done, config_enable = 1'b0, next_step = 1'b0;
  logic [11:0] config_addr = '0;
  logic [7:0] config_value = '0;
  logic [2:0] config_byte = '0;
  int total = 0, bad = 0, cyc = 0, t, n;
  logic [7:0] qa[$], qc[$];
  int qt[$];
  ucaspian_synapse_if sif();
  ucaspian_synapse dut (
    .clk(clk), .reset(reset), .enable(enable), .clear_act(clear_act), .clear_config(clear_config),
    .clear_done(clear_done), .config_addr(config_addr), .config_value(config_value),
    .config_byte(config_byte), .config_enable(config_enable), .next_step(next_step),
    .step_done(step_done), .syn(sif)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (sif.dend_vld && sif.dend_rdy) begin
    qa.push_back(sif.dend_addr);
    qc.push_back(sif.dend_charge);
    qt.push_back(cyc);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic cfg(input logic [11:0] a, input logic [7:0] w, input logic [7:0] nrn);
    config_addr = a;
    config_enable = 1'b1;
    config_byte = 3'd1;
    tick(1);
    config_byte = 3'd2;
    config_value = w;
    tick(1);
    config_byte = 3'd3;
    config_value = nrn;
    tick(1);
    config_enable = 1'b0;
  endtask
  task automatic launch(input logic [11:0] s, input logic [11:0] e, output int ta);
    qa.delete();
    qc.delete();
    qt.delete();
    sif.syn_start = s;
    sif.syn_end = e;
    sif.syn_vld = 1'b1;
    chk("syn_rdy_idle", 32'(sif.syn_rdy), 1);
    tick(1);
    ta = cyc;
    sif.syn_vld = 1'b0;
  endtask
  task automatic drain(input int cnt, input bit tog);
    for (int i = 0; i < 60 && qa.size() < cnt; i++) begin
      tick(1);
      if (tog) sif.dend_rdy = ~sif.dend_rdy;
    end
    sif.dend_rdy = 1'b1;
    tick(5);
    chk("event_count", 32'(qa.size()), 32'(cnt));
  endtask
  task automatic ev(input int i, input logic [7:0] a, input logic [7:0] c);
    chk($sformatf("ev%0d_addr", i), 32'(qa[i]), 32'(a));
    chk($sformatf("ev%0d_charge", i), 32'(qc[i]), 32'(c));
  endtask
  initial begin
    sif.syn_start = '0;
    sif.syn_end = '0;
    sif.syn_vld = 1'b0;
    sif.dend_rdy = 1'b1;
    tick(3);
    chk("rst_syn_rdy", 32'(sif.syn_rdy), 0);
    chk("rst_dend_vld", 32'(sif.dend_vld), 0);
    chk("rst_dend_addr", 32'(sif.dend_addr), 0);
    chk("rst_step_done", 32'(step_done), 0);
    chk("rst_clear_done", 32'(clear_done), 0);
    reset = 1'b0;
    tick(2);
    chk("idle_step_done", 32'(step_done), 1);
    cfg(12'h010, 8'd5, 8'd3);
    cfg(12'h011, 8'hFE, 8'd7);
    cfg(12'h012, 8'd1, 8'd9);
    launch(12'h010, 12'h012, t);
    drain(3, 1'b0);
    ev(0, 8'd3, 8'd5);
    ev(1, 8'd7, 8'hFE);
    ev(2, 8'd9, 8'd1);
    chk("t1_first_lat", 32'(qt[0]), 32'(t + 2));
    chk("t1_last_lat", 32'(qt[2]), 32'(t + 4));
    launch(12'h010, 12'h012, t);
    drain(3, 1'b1);
    ev(0, 8'd3, 8'd5);
    ev(1, 8'd7, 8'hFE);
    ev(2, 8'd9, 8'd1);
    cfg(12'hFFE, 8'd10, 8'd1);
    cfg(12'hFFF, 8'd11, 8'd2);
    cfg(12'h000, 8'd12, 8'd3);
    cfg(12'h001, 8'd13, 8'd4);
    launch(12'hFFE, 12'h001, t);
    drain(4, 1'b0);
    ev(0, 8'd1, 8'd10);
    ev(1, 8'd2, 8'd11);
    ev(2, 8'd3, 8'd12);
    ev(3, 8'd4, 8'd13);
    cfg(12'h020, 8'd1, 8'h20);
    cfg(12'h021, 8'd0, 8'h21);
    cfg(12'h022, 8'd2, 8'h22);
    cfg(12'h023, 8'd3, 8'h23);
    launch(12'h020, 12'h023, t);
    drain(3, 1'b0);
    ev(0, 8'h20, 8'd1);
    ev(1, 8'h22, 8'd2);
    ev(2, 8'h23, 8'd3);
    chk("drained_step_done", 32'(step_done), 1);
    clear_config = 1'b1;
    n = 0;
    for (int i = 0; i < 4200 && !clear_done; i++) begin
      tick(1);
      n++;
    end
    chk("clear_done", 32'(clear_done), 1);
    chk("clear_cycles_ok", 32'(n <= 4097), 1);
    chk("clear_step_done", 32'(step_done), 0);
    clear_config = 1'b0;
    tick(2);
    launch(12'h010, 12'h012, t);
    drain(0, 1'b0);
    for (int i = 0; i < 4; i++) cfg(12'(i), 8'd1, 8'(i + 1));
    launch(12'h000, 12'h0FF, t);
    tick(2);
    chk("run_dend_vld", 32'(sif.dend_vld), 1);
    reset = 1'b1;
    tick(1);
    chk("reset_dend_vld", 32'(sif.dend_vld), 0);
    chk("reset_syn_rdy", 32'(sif.syn_rdy), 0);
    reset = 1'b0;
    #1;
    chk("post_reset_syn_rdy", 32'(sif.syn_rdy), 1);
    qa.delete();
    tick(10);
    chk("post_reset_events", 32'(qa.size()), 0);
    launch(12'h000, 12'h0FF, t);
    tick(2);
    chk("run2_dend_vld", 32'(sif.dend_vld), 1);
    clear_act = 1'b1;
    tick(1);
    chk("clear_act_dend_vld", 32'(sif.dend_vld), 0);
    chk("clear_act_done", 32'(clear_done), 1);
    chk("clear_act_syn_rdy", 32'(sif.syn_rdy), 0);
    clear_act = 1'b0;
    #1;
    chk("post_clear_syn_rdy", 32'(sif.syn_rdy), 1);
    qa.delete();
    tick(10);
    chk("post_clear_events", 32'(qa.size()), 0);
    chk("post_clear_step_done", 32'(step_done), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
